// File: rtl/vec_mem_store_unit.sv
// ---------------------------------------------------------------------------
// vec_mem_store_unit
//
// MEM-stage store serializer. Accepts a scalar or 4-lane vector store from the
// EXE/MEM pipeline register and writes each enabled lane, one 32-bit word per
// accepted write, into a single-port data memory. While a store is in
// progress the upstream stages are stalled through stop_out. An internal store
// pointer supplies the base word address and can auto-advance on completion.
//
// Optional feature (macro STORE_PERF_CNT_EN):
//   Adds stall_cycles_out, a 16-bit saturating count of cycles with
//   stop_out = 1, cleared by reset. When the macro is undefined the port and
//   counter do not exist.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset
//   memWrite_in      store request from EXE/MEM
//   updateCnt_in     advance the store pointer when this store completes
//   select_in        1 = vector store (4 lanes), 0 = scalar store (lane 0)
//   lane_mask_in     per-lane write enable (bit i gates aluRes{i})
//   aluRes0_in..3    lane data
//   mem_ready        memory accepts the write this cycle
//   mem_we           memory write strobe
//   mem_addr         word address (ptr + lane, modulo 2^ADDR_W)
//   mem_wdata        write data
//   stop_out         stall to EXE/MEM and upstream stages
//   ptr_out          current store pointer
//   stall_cycles_out (STORE_PERF_CNT_EN only) stall cycle counter
// ---------------------------------------------------------------------------
module vec_mem_store_unit #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memWrite_in,
    input  logic              updateCnt_in,
    input  logic              select_in,
    input  logic [3:0]        lane_mask_in,
    input  logic [31:0]       aluRes0_in,
    input  logic [31:0]       aluRes1_in,
    input  logic [31:0]       aluRes2_in,
    input  logic [31:0]       aluRes3_in,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              stop_out,
    output logic [ADDR_W-1:0] ptr_out
`ifdef STORE_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cycles_out
`endif
);

    typedef enum logic {IDLE, STORE} state_t;

    state_t             state_reg, state_next;
    logic               stop_reg;
    logic [ADDR_W-1:0]  ptr_reg, ptr_next;
    logic [1:0]         curLane_reg, curLane_next;
    logic [3:0]         mask_reg;
    logic               updCnt_reg;
    logic               isVec_reg;
    logic [31:0]        laneData_reg [4];

    logic [31:0]        laneIn [4];
    logic [3:0]         effMask;
    logic [3:0]         laneAbove;
    logic               accept;
    logic [1:0]         firstLane;
    logic [1:0]         nextLane;
    logic               moreLanes;

    // Lowest set bit of a 4-bit mask; only meaningful for a non-zero mask.
    function automatic logic [1:0] lowestSet(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    assign laneIn[0] = aluRes0_in;
    assign laneIn[1] = aluRes1_in;
    assign laneIn[2] = aluRes2_in;
    assign laneIn[3] = aluRes3_in;

    // A scalar store only ever writes lane 0, whatever the mask says.
    assign effMask   = select_in ? lane_mask_in : {3'b000, lane_mask_in[0]};
    assign accept    = (state_reg == IDLE) && memWrite_in;
    assign firstLane = lowestSet(effMask);

    // Enabled lanes strictly above the current one; jumping straight to the
    // lowest of these means cleared lanes cost no cycles.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_above
            assign laneAbove[gi] = mask_reg[gi] & (curLane_reg < 2'(gi));
        end
    endgenerate

    assign nextLane  = lowestSet(laneAbove);
    assign moreLanes = |laneAbove;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        curLane_next = curLane_reg;
        case (state_reg)
            IDLE: begin
                if (memWrite_in) begin
                    curLane_next = firstLane;
                    if (effMask != 4'b0000) begin
                        state_next = STORE;
                    end else if (updateCnt_in) begin
                        // Nothing to write: the pointer still moves now.
                        ptr_next = ptr_reg + (select_in ? ADDR_W'(4) : ADDR_W'(1));
                    end
                end
            end
            STORE: begin
                if (mem_ready) begin
                    if (moreLanes) begin
                        curLane_next = nextLane;
                    end else begin
                        state_next = IDLE;
                        if (updCnt_reg) begin
                            ptr_next = ptr_reg + (isVec_reg ? ADDR_W'(4) : ADDR_W'(1));
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            stop_reg    <= 1'b0;
            ptr_reg     <= ADDR_W'(BASE_ADDR);
            curLane_reg <= 2'd0;
            mask_reg    <= 4'b0000;
            updCnt_reg  <= 1'b0;
            isVec_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                laneData_reg[i] <= 32'd0;
            end
        end else begin
            state_reg   <= state_next;
            stop_reg    <= (state_next == STORE);
            ptr_reg     <= ptr_next;
            curLane_reg <= curLane_next;
            if (accept) begin
                mask_reg   <= effMask;
                updCnt_reg <= updateCnt_in;
                isVec_reg  <= select_in;
                for (int i = 0; i < 4; i++) begin
                    laneData_reg[i] <= laneIn[i];
                end
            end
        end
    end

    // Outputs derive only from registered state, so they stay stable for as
    // long as mem_ready holds off the handshake.
    assign mem_we    = (state_reg == STORE);
    assign mem_addr  = mem_we ? (ptr_reg + ADDR_W'(curLane_reg)) : '0;
    assign mem_wdata = mem_we ? laneData_reg[curLane_reg] : 32'd0;
    assign stop_out  = stop_reg;
    assign ptr_out   = ptr_reg;

`ifdef STORE_PERF_CNT_EN
    logic [15:0] stallCnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_reg <= 16'd0;
        end else if (stop_reg && (stallCnt_reg != 16'hFFFF)) begin
            stallCnt_reg <= stallCnt_reg + 16'd1;
        end
    end

    assign stall_cycles_out = stallCnt_reg;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_vec_mem_store_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_store_unit
//
// Directed bench for vec_mem_store_unit (ADDR_W = 10, BASE_ADDR = 0). A table
// of store records is applied in a loop and every completed memory write is
// captured and compared against hand-computed addresses, data and timing.
// Address wrap with a held follow-on store, and reset in the middle of a
// store, are exercised as hand-written sequences.
// ---------------------------------------------------------------------------
module tb_vec_mem_store_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          memWrite_in;
    logic          updateCnt_in;
    logic          select_in;
    logic [3:0]    lane_mask_in;
    logic [31:0]   aluRes0_in, aluRes1_in, aluRes2_in, aluRes3_in;
    logic          mem_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          stop_out;
    logic [AW-1:0] ptr_out;
`ifdef STORE_PERF_CNT_EN
    logic [15:0]   stall_cycles_out;
`endif

    always #5 clk = ~clk;

    vec_mem_store_unit #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .memWrite_in  (memWrite_in),
        .updateCnt_in (updateCnt_in),
        .select_in    (select_in),
        .lane_mask_in (lane_mask_in),
        .aluRes0_in   (aluRes0_in),
        .aluRes1_in   (aluRes1_in),
        .aluRes2_in   (aluRes2_in),
        .aluRes3_in   (aluRes3_in),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .stop_out     (stop_out),
        .ptr_out      (ptr_out)
`ifdef STORE_PERF_CNT_EN
        ,
        .stall_cycles_out (stall_cycles_out)
`endif
    );

    typedef struct packed {
        logic            doReset;
        logic            sel;
        logic [3:0]      mask;
        logic            upd;
        logic [3:0][31:0] lane;
        logic [3:0]      waitCyc;
        logic [3:0]      nWr;
        logic [3:0][9:0] addr;
        logic [3:0][31:0] data;
        logic [3:0]      stopCyc;
        logic [9:0]      ptrEarly;
        logic [9:0]      ptrFinal;
    } vec_t;

    int cmpCount  = 0;
    int failCount = 0;

    // Capture of completed writes and stall activity
    int            wrCount;
    logic [AW-1:0] wrAddr [16];
    logic [31:0]   wrData [16];
    int            wrCyc  [16];
    int            stopCnt;
    logic [15:0]   stopHist;
    int            cyc;
    logic          heldValid;
    logic [AW-1:0] heldAddr;
    logic [31:0]   heldData;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] m,
                                input logic u, input logic [127:0] ln,
                                input logic [3:0] w, input logic [3:0] n,
                                input logic [39:0] ad, input logic [127:0] dt,
                                input logic [3:0] st, input logic [9:0] pe,
                                input logic [9:0] pf);
        vec_t v;
        v.doReset  = r;
        v.sel      = s;
        v.mask     = m;
        v.upd      = u;
        v.lane     = ln;
        v.waitCyc  = w;
        v.nWr      = n;
        v.addr     = ad;
        v.data     = dt;
        v.stopCyc  = st;
        v.ptrEarly = pe;
        v.ptrFinal = pf;
        return v;
    endfunction

    task automatic clearCap();
        wrCount   = 0;
        stopCnt   = 0;
        stopHist  = 16'd0;
        cyc       = 0;
        heldValid = 1'b0;
        heldAddr  = '0;
        heldData  = 32'd0;
    endtask

    // One clock cycle: sample at the falling edge, then set mem_ready for the
    // rising edge that ends this cycle.
    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        if (mem_we && heldValid) begin
            chk("hold_addr", 32'(mem_addr), 32'(heldAddr));
            chk("hold_data", mem_wdata, heldData);
        end
        heldValid = mem_we && !rdy;
        heldAddr  = mem_addr;
        heldData  = mem_wdata;
        if (mem_we && rdy) begin
            if (wrCount < 16) begin
                wrAddr[wrCount] = mem_addr;
                wrData[wrCount] = mem_wdata;
                wrCyc[wrCount]  = cyc;
            end
            wrCount++;
        end
        if (stop_out) begin
            stopCnt++;
            if (cyc < 16) stopHist[cyc] = 1'b1;
        end
        cyc++;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset       = 1'b1;
        memWrite_in = 1'b0;
        mem_ready   = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
    endtask

    task automatic driveStore(input logic s, input logic [3:0] m, input logic u,
                              input logic [127:0] ln);
        select_in    = s;
        lane_mask_in = m;
        updateCnt_in = u;
        aluRes0_in   = ln[31:0];
        aluRes1_in   = ln[63:32];
        aluRes2_in   = ln[95:64];
        aluRes3_in   = ln[127:96];
        memWrite_in  = 1'b1;
    endtask

    // Present a store for exactly one rising edge (accepted from IDLE).
    task automatic accept(input logic s, input logic [3:0] m, input logic u,
                          input logic [127:0] ln);
        @(negedge clk);
        driveStore(s, m, u, ln);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        memWrite_in = 1'b0;
    endtask

    initial begin
        logic [127:0] lnA, lnM, lnS, lnT, lnP, lnQ, lnR;
        logic [AW-1:0] expA [8];
        logic [31:0]   expD [8];
        int            expC [8];

        reset        = 1'b1;
        memWrite_in  = 1'b0;
        updateCnt_in = 1'b0;
        select_in    = 1'b0;
        lane_mask_in = 4'b0000;
        aluRes0_in   = 32'd0;
        aluRes1_in   = 32'd0;
        aluRes2_in   = 32'd0;
        aluRes3_in   = 32'd0;
        mem_ready    = 1'b1;

        lnA = {32'h11112222, 32'hEEEEFFFF, 32'hCCCCDDDD, 32'hAAAABBBB};
        lnM = {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
        lnS = {32'h44440000, 32'h33330000, 32'h22220000, 32'h5A5A1234};
        lnT = {32'h600D0003, 32'h600D0002, 32'h600D0001, 32'h600D0000};

        //        rst   sel   mask     upd   lanes  wait  nWr   addresses (lane3..0 order)         data                                         stop  ptrE     ptrF
        tbl[0] = mk(1'b1, 1'b1, 4'b1111, 1'b1, lnA, 4'd0, 4'd4, {10'd3, 10'd2, 10'd1, 10'd0}, lnA,                                         4'd4, 10'd0, 10'd4);
        tbl[1] = mk(1'b0, 1'b1, 4'b0000, 1'b1, lnA, 4'd0, 4'd0, 40'd0,                        128'd0,                                      4'd0, 10'd8, 10'd8);
        tbl[2] = mk(1'b0, 1'b1, 4'b1010, 1'b0, lnM, 4'd2, 4'd2, {10'd0, 10'd0, 10'd11, 10'd9}, {64'd0, 32'h04040404, 32'h02020202},      4'd4, 10'd8, 10'd8);
        tbl[3] = mk(1'b1, 1'b1, 4'b0000, 1'b1, lnM, 4'd0, 4'd0, 40'd0,                        128'd0,                                      4'd0, 10'd4, 10'd4);
        tbl[4] = mk(1'b0, 1'b0, 4'b1110, 1'b1, lnS, 4'd0, 4'd0, 40'd0,                        128'd0,                                      4'd0, 10'd5, 10'd5);
        tbl[5] = mk(1'b0, 1'b0, 4'b1111, 1'b1, lnS, 4'd0, 4'd1, {30'd0, 10'd5},               {96'd0, 32'h5A5A1234},                       4'd1, 10'd5, 10'd6);
        tbl[6] = mk(1'b0, 1'b1, 4'b1001, 1'b1, lnT, 4'd1, 4'd2, {10'd0, 10'd0, 10'd9, 10'd6}, {64'd0, 32'h600D0003, 32'h600D0000},      4'd3, 10'd6, 10'd10);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_stop",      32'(stop_out),  32'd0);
        chk("rst_ptr",       32'(ptr_out),   32'd0);
`ifdef STORE_PERF_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cycles_out), 32'd0);
`endif
        reset = 1'b0;

        // Table-driven stores
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].doReset) applyReset();
            accept(tbl[i].sel, tbl[i].mask, tbl[i].upd, tbl[i].lane);
            chk("ptr_at_accept", 32'(ptr_out), 32'(tbl[i].ptrEarly));
            clearCap();
            for (int c = 0; c < 12; c++) begin
                step((c < int'(tbl[i].waitCyc)) ? 1'b0 : 1'b1);
            end
            chk("wr_count", 32'(wrCount), 32'(tbl[i].nWr));
            for (int k = 0; k < int'(tbl[i].nWr) && k < 4; k++) begin
                chk("wr_addr", 32'(wrAddr[k]), 32'(tbl[i].addr[k]));
                chk("wr_data", wrData[k], tbl[i].data[k]);
            end
            if (tbl[i].nWr != 4'd0) begin
                chk("first_wr_cycle", 32'(wrCyc[0]), 32'(tbl[i].waitCyc));
                chk("last_wr_cycle", 32'(wrCyc[int'(tbl[i].nWr) - 1]),
                    32'(int'(tbl[i].waitCyc) + int'(tbl[i].nWr) - 1));
            end
            chk("stop_cycles", 32'(stopCnt), 32'(tbl[i].stopCyc));
            chk("ptr_final", 32'(ptr_out), 32'(tbl[i].ptrFinal));
`ifdef STORE_PERF_CNT_EN
            if (i == 0) chk("stall_cnt_after_full", 32'(stall_cycles_out), 32'd4);
`endif
            $display("vector %0d: sel=%0b mask=%b upd=%0b writes=%0d stop_cycles=%0d ptr=%0d",
                     i, tbl[i].sel, tbl[i].mask, tbl[i].upd, wrCount, stopCnt, ptr_out);
        end

        // Address wrap with a second store held on the inputs during the stall
        applyReset();
        @(negedge clk);
        driveStore(1'b1, 4'b0000, 1'b1, 128'd0);
        repeat (255) @(negedge clk);
        select_in = 1'b0;
        repeat (2) @(negedge clk);
        memWrite_in = 1'b0;
        chk("ptr_before_wrap", 32'(ptr_out), 32'd1022);

        lnP = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        lnQ = {32'hBEEF0003, 32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000};
        accept(1'b1, 4'b1111, 1'b1, lnP);
        driveStore(1'b1, 4'b1111, 1'b1, lnQ);
        clearCap();
        for (int c = 0; c < 14; c++) begin
            step(1'b1);
            if (c == 5) memWrite_in = 1'b0;
        end
        expA = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
        expD = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003,
                 32'hBEEF0000, 32'hBEEF0001, 32'hBEEF0002, 32'hBEEF0003};
        expC = '{0, 1, 2, 3, 5, 6, 7, 8};
        chk("wrap_wr_count", 32'(wrCount), 32'd8);
        for (int k = 0; k < 8 && k < wrCount; k++) begin
            chk("wrap_addr",  32'(wrAddr[k]), 32'(expA[k]));
            chk("wrap_data",  wrData[k], expD[k]);
            chk("wrap_cycle", 32'(wrCyc[k]), 32'(expC[k]));
        end
        chk("wrap_stop_cycles", 32'(stopCnt), 32'd8);
        chk("wrap_stop_gap", 32'(stopHist[4]), 32'd0);
        chk("wrap_ptr_final", 32'(ptr_out), 32'd6);
        $display("wrap+held: writes=%0d stop_cycles=%0d ptr=%0d", wrCount, stopCnt, ptr_out);

        // Reset in the middle of a 4-lane store
        applyReset();
        lnR = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
        accept(1'b1, 4'b1111, 1'b1, lnR);
        clearCap();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        reset = 1'b1;
        step(1'b1);
        chk("midrst_mem_we", 32'(mem_we),   32'd0);
        chk("midrst_stop",   32'(stop_out), 32'd0);
        chk("midrst_ptr",    32'(ptr_out),  32'd0);
`ifdef STORE_PERF_CNT_EN
        chk("midrst_stall_cnt", 32'(stall_cycles_out), 32'd0);
`endif
        reset = 1'b0;
        for (int c = 0; c < 6; c++) step(1'b1);
        chk("midrst_wr_count", 32'(wrCount), 32'd2);
        chk("midrst_wr0_addr", 32'(wrAddr[0]), 32'd0);
        chk("midrst_wr1_data", wrData[1], 32'h0B0B0B0B);
        chk("midrst_ptr_after", 32'(ptr_out), 32'd0);
        $display("reset mid-store: writes=%0d ptr=%0d", wrCount, ptr_out);

        $display("== %0d vectors applied, %0d miscompares ==", cmpCount, failCount);
        $finish;
    end

endmodule

// File: doc/vec_mem_store_unit.md
Name: vec_mem_store_unit

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs.
- Takes a scalar or 4-lane vector store and serializes the enabled lanes into a single-port, 32-bit-wide data memory, one word per accepted write.
- Drives the stop (stall) signal back to the EXE/MEM register while a store is in progress.
- Keeps an internal store pointer that auto-advances when updateCnt is set.

Parameters:
- ADDR_W, 10, word-address width of the data memory.
- BASE_ADDR, 0, store-pointer value after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- memWrite_in  in  1  store request from the EXE/MEM register.
- updateCnt_in  in  1  advance the store pointer when this store completes.
- select_in  in  1  1 = vector store (4 lanes), 0 = scalar store (lane 0 only).
- lane_mask_in  in  4  per-lane write enable; bit i gates aluRes{i}. Driven from resCompare_out.
- aluRes0_in..aluRes3_in  in  32 each  lane data.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- stop_out  out  1  stall to the EXE/MEM register and upstream stages.
- ptr_out  out  ADDR_W  current store pointer.

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - stop_out = 0.
  - ptr_out = BASE_ADDR.
  - All latched lanes and mask = 0.
- FSM states: IDLE, STORE.
- Acceptance: in IDLE, a cycle with memWrite_in = 1 is an accepted store.
  - Effective mask = lane_mask_in if select_in = 1, else lane_mask_in & 4'b0001.
  - On acceptance, latch the 4 lanes, the effective mask and updateCnt_in, and set cur_lane = lowest set bit of the mask.
- Mask = 0 on an accepted store:
  - No write is issued and the FSM stays in IDLE.
  - stop_out stays 0.
  - If updateCnt_in = 1, ptr still advances (+4 vector, +1 scalar) at the same edge.
- Mask != 0 on an accepted store: state -> STORE and stop_out -> 1 at the same edge.
- STORE outputs:
  - mem_we = 1.
  - mem_addr = ptr + cur_lane, modulo 2^ADDR_W.
  - mem_wdata = latched lane[cur_lane].
  - All three are held stable until mem_ready = 1.
- Handshake: a write completes on an edge where mem_we = 1 and mem_ready = 1.
  - If higher mask bits remain, cur_lane jumps to the next set bit. Cleared lanes are skipped and cost no cycles.
  - If the completed lane was the last set bit: state -> IDLE, mem_we -> 0 and stop_out -> 0. If the latched updateCnt = 1, ptr += 4 (vector) or +1 (scalar), wrapping modulo 2^ADDR_W.
- stop_out is registered and equals (state == STORE).
  - Inputs are sampled only in IDLE, so an instruction held by stop is accepted exactly once, in the first IDLE cycle after completion.
  - There is no back-to-back acceptance while in STORE.
- Latency with mem_ready tied to 1 and n set mask bits:
  - Writes occur on the n consecutive cycles starting the cycle after acceptance.
  - stop_out is high for exactly n cycles.
- Wait states: each cycle with mem_ready = 0 adds one stall cycle. Nothing else changes.
- Address wrap: with ptr = 2^ADDR_W − 2, lanes 2 and 3 are written to addresses 0 and 1.
- Reset during STORE: the in-flight store is discarded and all reset values apply at that edge. The remaining lanes are never written.
- memWrite_in during STORE: ignored; it is accepted only once back in IDLE.

Optional Feature:
- Macro STORE_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles_out (16 bits).
  - It counts cycles with stop_out = 1, saturates at 16'hFFFF and is cleared by reset.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
1. Vector, full mask, counter update.
   - Stimulus: reset; then memWrite = 1, select = 1, mask = 4'b1111, updateCnt = 1, lanes AAAABBBB / CCCCDDDD / EEEEFFFF / 11112222, mem_ready = 1.
   - Response: writes to addresses 0, 1, 2, 3 with those data on 4 consecutive cycles; stop_out high 4 cycles; then ptr_out = 4.
2. Sparse mask with wait states.
   - Stimulus: mask = 4'b1010, ptr = 8; mem_ready low for 2 cycles on the first write.
   - Response: first write addr 9 with lane1 data, held 3 cycles; then addr 11 with lane3 data; stop_out high 4 cycles; lanes 0 and 2 never written.
3. Scalar store.
   - Stimulus: select = 0, mask = 4'b1111, updateCnt = 1, ptr = 5.
   - Response: single write, addr 5, data aluRes0; ptr_out = 6.
4. Empty mask.
   - Stimulus: mask = 0, updateCnt = 1.
   - Response: mem_we never asserts; stop_out stays 0; ptr advances by 4 at the acceptance edge.
5. Wrap and held instruction.
   - Stimulus: ptr = 1022 (ADDR_W = 10), full vector store; a second store is held on the inputs during the stall.
   - Response: writes to 1022, 1023, 0, 1; the second store is accepted once, immediately after stop_out falls, and its first write goes to addr 2.
6. Reset mid-store.
   - Stimulus: assert reset after the 2nd of 4 writes completes.
   - Response: mem_we = 0, stop_out = 0, ptr_out = 0 at the next edge; no further writes.
   - With STORE_PERF_CNT_EN: stall_cycles_out = 0 after this reset, and equals 4 after scenario 1.
